// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 sliding-window generator for 1-bit images
module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pix_valid_i,
  input  logic       pix_in_i,
  input  logic       sof_i,
  output logic       win_valid_o,
  output logic [8:0] win_data_o,
  output logic       win_last_o,
  output logic       frame_done_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [IMG_W-1:0] lb1_q, lb2_q;
  logic [8:0]       win_q, win_d;
  logic             complete, last_pix;

  logic             win_valid_q, win_valid_d;
  logic [8:0]       win_data_q, win_data_d;
  logic             win_last_q, win_last_d;

  // Position tracking, window shift and output next-state
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    complete    = 1'b0;
    last_pix    = 1'b0;
    // sof relocates the accepted pixel to the frame origin, dropping any partial frame
    cur_col     = sof_i ? '0 : col_q;
    cur_row     = sof_i ? '0 : row_q;

    if (pix_valid_i) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end

      // Shift left one column; the right column is {row r-2, row r-1, row r}
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]   = win_q[3*i+1];
        win_d[3*i+1] = win_q[3*i+2];
      end
      win_d[2] = lb2_q[cur_col];
      win_d[5] = lb1_q[cur_col];
      win_d[8] = pix_in_i;

      complete = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      last_pix = complete && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    win_valid_d = complete;
    win_data_d  = complete ? win_d : win_data_q;
    win_last_d  = last_pix;
  end

  // Counters, window registers and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_last_q  <= win_last_d;
    end
  end

  // Line buffers carry no reset: stale contents are never exposed by the c>=2 / r>=2 gate
  always_ff @(posedge clk_i) begin
    if (pix_valid_i) begin
      lb2_q[cur_col] <= lb1_q[cur_col];
      lb1_q[cur_col] <= pix_in_i;
    end
  end

  assign win_valid_o  = win_valid_q;
  assign win_data_o   = win_data_q;
  assign win_last_o   = win_last_q;
  assign frame_done_o = win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - directed self-checking bench for conv_window_gen
module tb_conv_window_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       v4, p4, s4;
  logic       wv4, wl4, fd4;
  logic [8:0] wd4;
  logic       v28, p28, s28;
  logic       wv28, wl28, fd28;
  logic [8:0] wd28;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  conv_window_gen #(.IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .pix_valid_i(v4), .pix_in_i(p4), .sof_i(s4),
    .win_valid_o(wv4), .win_data_o(wd4), .win_last_o(wl4), .frame_done_o(fd4)
  );

  conv_window_gen u_dut28 (
    .clk_i(clk), .rst_i(rst), .pix_valid_i(v28), .pix_in_i(p28), .sof_i(s28),
    .win_valid_o(wv28), .win_data_o(wd28), .win_last_o(wl28), .frame_done_o(fd28)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step4(input logic v, input logic p, input logic s);
    v4 = v; p4 = p; s4 = s;
    @(posedge clk); #1;
    v4 = 1'b0; p4 = 1'b0; s4 = 1'b0;
  endtask

  task automatic step28(input logic v, input logic p, input logic s);
    v28 = v; p28 = p; s28 = s;
    @(posedge clk); #1;
    v28 = 1'b0; p28 = 1'b0; s28 = 1'b0;
  endtask

  function automatic logic pix4(input int pat, input int r, input int c);
    case (pat)
      0:       return 1'b1;
      1:       return ((r + c) % 2) == 1;
      default: return (r == 1) && (c == 1);
    endcase
  endfunction

  function automatic logic pix28(input int r, input int c);
    return ((r * 7 + c * 3) % 5) < 2;
  endfunction

  function automatic logic [8:0] win28(input int r0, input int c0);
    logic [8:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[3*i+j] = pix28(r0 + i, c0 + j);
    return w;
  endfunction

  // exp packs the four windows in emission order, first window in the top bits
  task automatic frame4(input string tag, input int pat, input bit gaps, input logic [35:0] exp);
    int k = 0;
    logic [8:0] last_w = 9'h000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (gaps) begin
          int n = $urandom_range(0, 2);
          for (int g = 0; g < n; g++) begin
            step4(1'b0, 1'b0, 1'b0);
            chk({tag, " gap valid"}, 32'(wv4), 32'd0);
            if (k > 0) chk({tag, " gap hold"}, 32'(wd4), 32'(last_w));
          end
        end
        step4(1'b1, pix4(pat, r, c), 1'b0);
        if (r >= 2 && c >= 2) begin
          last_w = exp[35 - 9*k -: 9];
          chk({tag, " valid"}, 32'(wv4), 32'd1);
          chk({tag, " data"}, 32'(wd4), 32'(last_w));
          chk({tag, " last"}, 32'(wl4), 32'(k == 3));
          chk({tag, " done"}, 32'(fd4), 32'(k == 3));
          k++;
        end else begin
          chk({tag, " idle valid"}, 32'(wv4), 32'd0);
        end
      end
    end
    step4(1'b0, 1'b0, 1'b0);
    chk({tag, " post valid"}, 32'(wv4), 32'd0);
    chk({tag, " post done"}, 32'(fd4), 32'd0);
  endtask

  initial begin
    int nwin;
    int nlast;
    rst = 1'b1;
    v4 = 1'b0; p4 = 1'b0; s4 = 1'b0;
    v28 = 1'b0; p28 = 1'b0; s28 = 1'b0;
    @(posedge clk); #1;
    chk("reset valid", 32'(wv4), 32'd0);
    chk("reset data", 32'(wd4), 32'd0);
    chk("reset last", 32'(wl4), 32'd0);
    chk("reset done", 32'(fd4), 32'd0);
    chk("reset data28", 32'(wd28), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    frame4("t1 ones", 0, 1'b0, {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF});
    frame4("t2 checker", 1, 1'b0, {9'h0AA, 9'h155, 9'h155, 9'h0AA});
    frame4("t3 single", 2, 1'b0, {9'h010, 9'h008, 9'h002, 9'h001});
    frame4("t4 gaps", 1, 1'b1, {9'h0AA, 9'h155, 9'h155, 9'h0AA});

    // Abort in the middle of row 2, with a pixel offered while reset is held
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (r < 2 || c < 2) step4(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5 rst valid", 32'(wv4), 32'd0);
    chk("t5 rst data", 32'(wd4), 32'd0);
    v4 = 1'b1; p4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; p4 = 1'b0;
    chk("t5 rst valid2", 32'(wv4), 32'd0);
    chk("t5 rst last", 32'(wl4), 32'd0);
    chk("t5 rst done", 32'(fd4), 32'd0);
    rst = 1'b0;
    frame4("t5 ones", 0, 1'b0, {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF});

    // Frame A up to (2,0); the pixel at (2,1) carries sof and starts frame B
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 28; c++)
        if (r < 2 || c < 1) begin
          step28(1'b1, pix28(r, c), 1'b0);
          chk("t6 A valid", 32'(wv28), 32'd0);
          chk("t6 A done", 32'(fd28), 32'd0);
        end
    nwin = 0;
    nlast = 0;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        step28(1'b1, pix28(r, c), (r == 0) && (c == 0));
        if (wv28) nwin++;
        if (wl28) nlast++;
        if (r >= 2 && c >= 2) begin
          chk("t6 B valid", 32'(wv28), 32'd1);
          chk("t6 B data", 32'(wd28), 32'(win28(r - 2, c - 2)));
          chk("t6 B last", 32'(wl28), 32'((r == 27) && (c == 27)));
          chk("t6 B done", 32'(fd28), 32'((r == 27) && (c == 27)));
        end else begin
          chk("t6 B idle", 32'(wv28), 32'd0);
        end
      end
    end
    chk("t6 window count", 32'(nwin), 32'd676);
    chk("t6 last count", 32'(nlast), 32'd1);
    step28(1'b0, 1'b0, 1'b0);
    chk("t6 post done", 32'(fd28), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
